// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter: two requesters share one bank of flip-flop registers.
// A round-robin arbiter picks one request per transaction. A two-state FSM
// performs the access on the grant edge and spends one cycle in ACCESS, so
// gnt/rvalid are single-cycle pulses and throughput is one access per 2 cycles.
module dff_bank_arbiter #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [WIDTH-1:0]  wdata0,
  input  logic [WIDTH-1:0]  wdata1,
  output logic [1:0]        gnt,
  output logic [WIDTH-1:0]  rdata,
  output logic              rvalid
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state, state_nxt;
  logic                last;       // requester granted most recently
  logic                owner;      // requester that wins this transaction
  logic                start;      // an access is performed at the coming edge
  logic                acc_we;
  logic [ADDR_W-1:0]   acc_addr;
  logic [WIDTH-1:0]    acc_wdata;
  logic [WIDTH-1:0]    bank [DEPTH];

  // Arbitration, next-state and access-operand selection.
  always_comb begin
    owner     = 1'b0;
    state_nxt = state;
    start     = 1'b0;
    case (req)
      2'b01:   owner = 1'b0;
      2'b10:   owner = 1'b1;
      2'b11:   owner = ~last;
      default: owner = 1'b0;
    endcase
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          start     = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    acc_we    = owner ? we[1]  : we[0];
    acc_addr  = owner ? addr1  : addr0;
    acc_wdata = owner ? wdata1 : wdata0;
  end

  // FSM state, arbitration history and the one-cycle grant/response pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      last   <= 1'b1;
      gnt    <= 2'b00;
      rvalid <= 1'b0;
    end else begin
      state  <= state_nxt;
      gnt    <= 2'b00;
      rvalid <= 1'b0;
      if (start) begin
        last   <= owner;
        gnt    <= owner ? 2'b10 : 2'b01;
        rvalid <= ~acc_we;
      end
    end
  end

  // Register bank and read-data register; both change only on a granted access.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata <= '0;
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
    end else if (start) begin
      if (acc_we) bank[acc_addr] <= acc_wdata;
      else        rdata          <= bank[acc_addr];
    end
  end

endmodule
